// File: rtl/platform_spawner.sv
// platform_spawner: scroll-driven platform generator with LFSR placement and a 4-deep spawn FIFO
module platform_spawner #(
    parameter int          GAME_VIEW_LEFT_BORDER_X  = 340,
    parameter int          GAME_VIEW_RIGHT_BORDER_X = 682,
    parameter int          PLATFORM_WIDTH           = 100,
    parameter int          MIN_GAP                  = 60,
    parameter logic [15:0] SEED                     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_state,
    input  logic        shift_pulse,
    input  logic [4:0]  shift_amount,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [10:0] spawn_x,
    output logic [15:0] spawn_count,
    output logic        overflow
);
    localparam int RANGE = GAME_VIEW_RIGHT_BORDER_X - GAME_VIEW_LEFT_BORDER_X - PLATFORM_WIDTH;
    typedef enum logic [1:0] {STOPPED, RUNNING, ENDED} state_t;
    state_t      state;
    logic [9:0]  acc;
    logic [9:0]  gap_target;
    logic [15:0] lfsr;
    logic [10:0] mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  used;
    logic [10:0] sum;
    logic [7:0]  off;
    logic [10:0] new_x;
    logic        start, stop, run, spawn, full, pop, push;
    always_comb begin
        start = state == STOPPED && game_state == 2'd1;
        stop  = state == RUNNING && game_state == 2'd2;
        run   = state == RUNNING && game_state != 2'd2;
        sum   = {1'b0, acc} + {6'd0, shift_amount};
        spawn = run && shift_pulse && sum >= {1'b0, gap_target};
        off   = lfsr[7:0] >= 8'(RANGE) ? lfsr[7:0] - 8'(RANGE) : lfsr[7:0];
        new_x = 11'(GAME_VIEW_LEFT_BORDER_X) + {3'd0, off};
        full  = used == 3'd4;
        pop   = used != 3'd0 && spawn_ready;
        push  = spawn && (!full || pop);
    end
    assign spawn_valid = used != 3'd0;
    assign spawn_x     = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STOPPED;
            acc         <= '0;
            gap_target  <= 10'(MIN_GAP);
            lfsr        <= SEED;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            used        <= '0;
            spawn_count <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (start) state <= RUNNING;
            else if (stop) state <= ENDED;
            else if (state == ENDED && game_state == 2'd0) state <= STOPPED;
            if (start || stop) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                used   <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= new_x;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                used <= used + {2'd0, push} - {2'd0, pop};
            end
            // placement and next gap both come from the LFSR value before it advances
            if (start) begin
                acc        <= '0;
                gap_target <= 10'(MIN_GAP);
            end else if (spawn) begin
                acc        <= 10'(sum - {1'b0, gap_target});
                gap_target <= 10'(MIN_GAP) + {3'd0, lfsr[14:8]};
                lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end else if (run && shift_pulse) begin
                acc <= sum[9:0];
            end
            if (start) spawn_count <= '0;
            else if (push && !stop && spawn_count != 16'hFFFF) spawn_count <= spawn_count + 16'd1;
            if (start) overflow <= 1'b0;
            else if (spawn && !push) overflow <= 1'b1;
        end
    end
endmodule
